// File: rtl/spk_pkg.sv
// Shared definitions for the spike-processing front end.
//   asm_state_t  : byte assembler FSM states
//   clog2_min1() : $clog2 clamped to at least 1 bit, for index/tag widths
//   BYTE_W       : width of one incoming stream byte
package spk_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ASM_IDLE    = 1'b0,
        ASM_COLLECT = 1'b1
    } asm_state_t;

    // A field that only ever holds one value still needs one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sample_stream_assembler_if.sv
// Byte-in / sample-out bus of the sample stream assembler.
//   byte side   : byte_in, byte_valid, byte_sof, lsb_first, channel_in  (producer -> assembler)
//   sample side : sample_out, sample_ch, sample_valid (assembler -> consumer), sample_ready (back)
//   master : producer/consumer environment
//   slave  : the assembler
interface sample_stream_assembler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_sof;
    logic                  lsb_first;
    logic [CH_W-1:0]       channel_in;
    logic [DATA_WIDTH-1:0] sample_out;
    logic [CH_W-1:0]       sample_ch;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output byte_in, byte_valid, byte_sof, lsb_first, channel_in, sample_ready,
        input  sample_out, sample_ch, sample_valid
    );

    modport slave (
        input  byte_in, byte_valid, byte_sof, lsb_first, channel_in, sample_ready,
        output sample_out, sample_ch, sample_valid
    );
endinterface

// File: rtl/sample_stream_assembler_fifo.sv
// sample_fifo: small show-ahead FIFO, also used by the event-output path.
//   push/push_data : write request; accepted if not full, or if full and popping this cycle
//   full / empty   : occupancy flags
//   pop            : consume head; ignored while empty
//   head           : current head entry, valid whenever !empty
module sample_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the same cycle, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sample_stream_assembler.sv
// sample_stream_assembler: packs an 8-bit byte stream into DATA_WIDTH-bit samples tagged with
// a channel index, and buffers them in a show-ahead FIFO toward the processing system.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : byte input side and sample valid/ready output side
//   frame_err   : 1-cycle pulse, partial sample discarded (sof resync or inter-byte timeout)
//   overflow    : 1-cycle pulse, completed sample dropped because the FIFO was full
//   drop_count  : saturating count of overflow events
//   busy        : assembler is mid-sample
module sample_stream_assembler
    import spk_pkg::*;
#(
    parameter int  DATA_WIDTH     = 16,
    parameter int  NUM_UNITS      = 4,
    parameter int  FIFO_DEPTH     = 4,
    parameter int  TIMEOUT_CYCLES = 255,
    parameter int  CNT_W          = 8,
    localparam int CH_W           = clog2_min1(NUM_UNITS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sample_stream_assembler_if.slave  bus,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      busy
);
    localparam int BYTES = DATA_WIDTH / BYTE_W;
    localparam int IDX_W = clog2_min1(BYTES);
    localparam int TMR_W = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam int ENT_W = DATA_WIDTH + CH_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    asm_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] word;
    logic [CH_W-1:0]       ch_q;
    logic                  lsb_q;
    logic [TMR_W-1:0]      timer;
    logic                  push_q;
    logic [ENT_W-1:0]      push_data;

    logic                  start;
    logic [DATA_WIDTH-1:0] first_word, cont_word;
    logic                  fifo_full, fifo_empty, drop;
    logic [ENT_W-1:0]      fifo_head;

    // Drop byte b into slot k of w; MSB-first fills from the top, LSB-first from bit 0.
    function automatic logic [DATA_WIDTH-1:0] put_slot(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [IDX_W-1:0]      k,
                                                       input logic                  lsb,
                                                       input logic [7:0]            b);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        for (int s = 0; s < BYTES; s++) begin
            if (int'(k) == s) begin
                if (lsb) r[BYTE_W*s +: BYTE_W] = b;
                else     r[DATA_WIDTH-1-BYTE_W*s -: BYTE_W] = b;
            end
        end
        return r;
    endfunction

    // A byte opens a new sample in IDLE, or with sof mid-sample (same-cycle restart).
    assign start      = bus.byte_valid & ((state == ASM_IDLE) | bus.byte_sof);
    assign first_word = put_slot('0, '0, bus.lsb_first, bus.byte_in);
    assign cont_word  = put_slot(word, idx, lsb_q, bus.byte_in);
    assign busy       = (state == ASM_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ASM_IDLE;
            idx       <= '0;
            word      <= '0;
            ch_q      <= '0;
            lsb_q     <= 1'b0;
            timer     <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            push_q    <= 1'b0;
            if (start) begin
                if (state == ASM_COLLECT) frame_err <= 1'b1;
                timer <= '0;
                if (BYTES == 1) begin
                    push_q    <= 1'b1;
                    push_data <= {bus.channel_in, first_word};
                    state     <= ASM_IDLE;
                end else begin
                    word  <= first_word;
                    ch_q  <= bus.channel_in;
                    lsb_q <= bus.lsb_first;
                    idx   <= IDX_W'(1);
                    state <= ASM_COLLECT;
                end
            end else if (state == ASM_COLLECT) begin
                if (bus.byte_valid) begin
                    timer <= '0;
                    if (idx == LAST_IDX) begin
                        push_q    <= 1'b1;
                        push_data <= {ch_q, cont_word};
                        idx       <= '0;
                        state     <= ASM_IDLE;
                    end else begin
                        word <= cont_word;
                        idx  <= idx + 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (timer == TMR_LAST) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                        timer     <= '0;
                        state     <= ASM_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            end
        end
    end

    // Completed samples enter the FIFO one cycle after their last byte (push_q stage).
    sample_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (bus.sample_ready),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.sample_valid              = ~fifo_empty;
    assign {bus.sample_ch, bus.sample_out} = fifo_head;

    // Full without a concurrent pop: the FIFO refuses the push.
    assign drop = push_q & fifo_full & ~(bus.sample_ready & ~fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= drop;
            if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end
endmodule
